mult_share_arbiter: RTL and testbench

//   Shares one combinational 3x3 unsigned `multiplier` (A,B -> P) between NUM_REQ requesters.
//   - Round-robin arbitration; valid/ready handshake on each request port.
//   - Registered operands and result.
//   - Single response channel tagged with the requester index.
//   - Sits between the operand sources and the one multiplier instance.

---
 rtl/mult_arb_pkg.sv | 16 +
 rtl/mult_arb_rr_pick.sv | 39 +++
 rtl/multiplier.sv | 14 +
 rtl/mult_share_arbiter.sv | 128 ++++++++++++
 tb/tb_mult_share_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_arb_pkg.sv
// Shared types and widths for the multiplier-sharing arbiter.
//   state_t : arbiter FSM states (IDLE -> CALC -> HOLD)
//   OPW     : operand width of the shared multiplier
//   PW      : product width (OPW*2, cannot overflow)
package mult_arb_pkg;

  localparam int unsigned OPW = 3;
  localparam int unsigned PW  = 6;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    HOLD
  } state_t;

endpackage

// File: rtl/mult_arb_rr_pick.sv
// Combinational round-robin picker: grants the first asserted request found
// searching upward from rr_ptr, wrapping at NUM_REQ.
//   req    : request vector
//   rr_ptr : highest-priority index this round (0..NUM_REQ-1)
//   gnt    : one-hot grant, zero when no request
//   gnt_id : index of the granted request
//   any    : at least one request asserted
module mult_arb_rr_pick #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     gnt_id,
  output logic               any
);

  int unsigned    idx;
  logic [IDW-1:0] idx_w;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = 0;
    idx_w  = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx   = (32'(rr_ptr) + off) % NUM_REQ;
      idx_w = IDW'(idx);
      if (!any && req[idx_w]) begin
        any        = 1'b1;
        gnt[idx_w] = 1'b1;
        gnt_id     = idx_w;
      end
    end
  end

endmodule

// File: rtl/multiplier.sv
// Combinational unsigned multiplier shared by all requesters.
//   a, b : OPW-bit unsigned operands
//   p    : PW-bit unsigned product
module multiplier
  import mult_arb_pkg::*;
(
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic [PW-1:0]  p
);

  assign p = PW'(a) * PW'(b);

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one 3x3 multiplier between NUM_REQ requesters.
// Operands and result are registered; one tagged response channel.
//   clk, rst  : clock, synchronous active-high reset
//   req_valid : per-requester valid          req_ready : one-hot (or zero) accept
//   req_a/b   : packed operands, requester i at bits [3i+2:3i]
//   rsp_valid : response valid               rsp_ready : response consumer ready
//   rsp_id    : owning requester index       rsp_p     : product
// Build option: MULT_ARB_FAST_EN lets HOLD re-arbitrate while the response
// is accepted, going straight to CALC (one product per 2 cycles).
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [OPW*NUM_REQ-1:0] req_a,
  input  logic [OPW*NUM_REQ-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [PW-1:0]          rsp_p
);

  state_t             state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, gnt_id_q, rsp_id_q;
  logic [IDW-1:0]     next_ptr, pick_ptr, pick_id;
  logic [OPW-1:0]     op_a_q, op_b_q, sel_a, sel_b;
  logic [PW-1:0]      rsp_p_q, mult_p;
  logic               rsp_valid_q, arb_en, pick_any, hs;
  logic [NUM_REQ-1:0] pick_gnt;

  // Pointer just past the current owner, wrapping for non-power-of-two NUM_REQ.
  assign next_ptr = (gnt_id_q == IDW'(NUM_REQ - 1)) ? '0 : gnt_id_q + 1'b1;

  mult_arb_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req   (req_valid),
    .rr_ptr(pick_ptr),
    .gnt   (pick_gnt),
    .gnt_id(pick_id),
    .any   (pick_any)
  );

  multiplier u_mult (
    .a(op_a_q),
    .b(op_b_q),
    .p(mult_p)
  );

  always_comb begin
    pick_ptr = rr_ptr_q;
    arb_en   = 1'b0;
    unique case (state_q)
      IDLE: arb_en = 1'b1;
      HOLD: begin
`ifdef MULT_ARB_FAST_EN
        // rr_ptr is updated at this same edge, so arbitrate with its next value.
        pick_ptr = next_ptr;
        arb_en   = rsp_ready;
`endif
      end
      default: ;
    endcase
  end

  assign req_ready = (arb_en && !rst) ? pick_gnt : '0;
  assign hs        = arb_en & pick_any & ~rst;

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) begin
        sel_a = req_a[i*OPW +: OPW];
        sel_b = req_b[i*OPW +: OPW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (hs) state_d = CALC;
      CALC: state_d = HOLD;
      HOLD: if (rsp_ready) state_d = hs ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gnt_id_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_p_q     <= '0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        op_a_q   <= sel_a;
        op_b_q   <= sel_b;
        gnt_id_q <= pick_id;
      end
      if (state_q == CALC) begin
        rsp_p_q     <= mult_p;
        rsp_id_q    <= gnt_id_q;
        rsp_valid_q <= 1'b1;
      end else if (state_q == HOLD && rsp_ready) begin
        rsp_valid_q <= 1'b0;
        rr_ptr_q    <= next_ptr;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_p     = rsp_p_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed self-checking bench for mult_share_arbiter with a response scoreboard
// and a small round-robin reference model.
module tb_mult_share_arbiter;

  localparam int N = 4;
`ifdef MULT_ARB_FAST_EN
  localparam int TPUT = 2;
`else
  localparam int TPUT = 3;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [3*N-1:0] req_a;
  logic [3*N-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [5:0]     rsp_p;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mult_share_arbiter #(
    .NUM_REQ(N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_p    (rsp_p)
  );

  typedef struct packed {
    logic [1:0] id;
    logic [5:0] p;
  } rsp_t;

  rsp_t       sb[$];
  int         gnt_exp[$];
  int         errors = 0;
  int         checks = 0;
  int         ptr_m = 0;
  int         hs_cyc = -100;
  int         last_rsp_cyc = -100;
  logic       prev_vld = 1'b0;
  logic       auto_drop = 1'b1;
  logic       tput_en = 1'b0;
  int         ready_cnt[N];
  logic [N-1:0] hs_mask;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] a, input logic [2:0] b);
    req_valid[i]    = v;
    req_a[3*i +: 3] = a;
    req_b[3*i +: 3] = b;
  endtask

  // One cycle: sample at negedge, score, then advance to #1 after posedge.
  task automatic step();
    int   g;
    logic found;
    logic [2:0] ga, gb;
    rsp_t e;
    @(negedge clk);
    hs_mask = '0;
    if (rst !== 1'b1) begin
      check("ready_onehot0", 32'($onehot0(req_ready)), 1);
      if (rsp_valid === 1'b1 && !prev_vld) check("latency", cyc - hs_cyc, 2);
      if (rsp_valid === 1'b1 && rsp_ready) begin
        check("rsp_expected", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("rsp_id", rsp_id, e.id);
          check("rsp_p", rsp_p, e.p);
        end
        ptr_m = (int'(rsp_id) + 1) % N;
        if (tput_en && last_rsp_cyc >= 0) check("throughput", cyc - last_rsp_cyc, TPUT);
        last_rsp_cyc = cyc;
      end
      prev_vld = (rsp_valid === 1'b1);
      found = 1'b0;
      g = 0;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (ptr_m + k) % N;
        if (!found && req_valid[idx]) begin
          found = 1'b1;
          g = idx;
        end
      end
      if (req_ready != '0) begin
        check("grant_model", req_ready, 1 << g);
        for (int i = 0; i < N; i++) if (req_ready[i]) ready_cnt[i]++;
        hs_mask = req_ready & req_valid;
        if (hs_mask != '0) begin
          ga = req_a[3*g +: 3];
          gb = req_b[3*g +: 3];
          sb.push_back('{id: 2'(g), p: 6'(int'(ga) * int'(gb))});
          hs_cyc = cyc;
          if (gnt_exp.size() > 0) check("gnt_order", g, gnt_exp.pop_front());
        end
      end
    end
    @(posedge clk);
    #1;
    if (auto_drop) req_valid = req_valid & ~hs_mask;
  endtask

  task automatic wait_hs(input int maxc);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (hs_mask == '0 && n < maxc);
    check("hs_timeout", 32'(hs_mask != '0), 1);
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((sb.size() > 0 || rsp_valid === 1'b1 || req_valid != '0) && n < maxc) begin
      step();
      n++;
    end
    check("drain_done", 32'(sb.size() == 0 && rsp_valid !== 1'b1 && req_valid == '0), 1);
  endtask

  task automatic clear_model();
    sb.delete();
    gnt_exp.delete();
    ptr_m    = 0;
    prev_vld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) ready_cnt[i] = 0;

    // Reset held with all requests valid.
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_ready", req_ready, 0);
      check("rst_valid", rsp_valid, 0);
      check("rst_p", rsp_p, 0);
      check("rst_id", rsp_id, 0);
      @(posedge clk);
      #1;
    end
    rst       = 1'b0;
    req_valid = '0;
    clear_model();

    // Single request from requester 2: 5*6.
    set_req(2, 1'b1, 3'd5, 3'd6);
    gnt_exp.push_back(2);
    drain(20);
    check("single_ready_pulses", ready_cnt[2], 1);
    check("single_other_ready", ready_cnt[0] + ready_cnt[1] + ready_cnt[3], 0);

    // Round robin from reset: all valid, a=i+1, b=7.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
    auto_drop = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 3'(i + 1), 3'd7);
    gnt_exp.push_back(0);
    gnt_exp.push_back(1);
    gnt_exp.push_back(2);
    gnt_exp.push_back(3);
    gnt_exp.push_back(0);
    for (int n = 0; n < 40 && gnt_exp.size() > 0; n++) step();
    check("rr_grants_done", gnt_exp.size(), 0);
    req_valid = '0;
    auto_drop = 1'b1;
    drain(20);

    // Backpressure: 7*7 held for 5 cycles while others are waiting.
    rsp_ready = 1'b0;
    set_req(0, 1'b1, 3'd7, 3'd7);
    wait_hs(20);
    set_req(1, 1'b1, 3'd3, 3'd2);
    set_req(2, 1'b1, 3'd4, 3'd4);
    set_req(3, 1'b1, 3'd0, 3'd6);
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", rsp_valid, 1);
      check("bp_p", rsp_p, 49);
      check("bp_id", rsp_id, 0);
      check("bp_no_ready", req_ready, 0);
      step();
    end
    rsp_ready = 1'b1;
    drain(40);

    // Mid-operation reset: ptr made nonzero first, then reset while in CALC.
    set_req(2, 1'b1, 3'd1, 3'd1);
    drain(20);
    set_req(3, 1'b1, 3'd3, 3'd3);
    wait_hs(20);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
    check("mid_rst_valid", rsp_valid, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("mid_rst_no_rsp", rsp_valid, 0);
    end
    set_req(1, 1'b1, 3'd2, 3'd3);
    set_req(3, 1'b1, 3'd6, 3'd5);
    gnt_exp.push_back(1);
    gnt_exp.push_back(3);
    drain(30);

    // Continuous requests: response spacing.
    auto_drop    = 1'b0;
    tput_en      = 1'b1;
    last_rsp_cyc = -100;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 3'($urandom_range(7)), 3'($urandom_range(7)));
    for (int n = 0; n < 16; n++) step();
    req_valid = '0;
    tput_en   = 1'b0;
    auto_drop = 1'b1;
    drain(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
